// File: rtl/float32_normalize_pkg.sv
// Shared float types for the arithmetic pipeline: IEEE single-precision, integer,
// and the unnormalised raw result that the arithmetic stages hand to the normaliser.
package float32_normalize_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 28;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } Float32;

    typedef logic signed [31:0] Int32;

    // Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
    typedef struct packed {
        logic                sign;
        logic signed [9:0]   exponent;
        logic [MANT_W-1:0]   mantissa;
    } RawFloat;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } NormState;

endpackage

// File: rtl/float32_round.sv
// Round-to-nearest-even on a normalised raw mantissa, then pack into Float32
// with flush-to-zero and overflow-to-infinity.
import float32_normalize_pkg::*;

module float32_round (
    input  logic                sign,
    input  logic signed [10:0]  exponent,
    input  logic [MANT_W-1:0]   mantissa,
    input  logic                zeroFlag,
    output Float32              result
);

    localparam logic signed [10:0] EXP_LIMIT = 11'(EXP_MAX);

    logic               roundUp;
    logic [24:0]        summed;
    logic [22:0]        fraction;
    logic               hidden;
    logic signed [10:0] finalExp;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        roundUp  = mantissa[2] & (mantissa[1] | mantissa[0] | mantissa[3]);
        summed   = mantissa[27:3] + 25'(roundUp);
        fraction = summed[22:0];
        hidden   = summed[23];
        finalExp = exponent;
        result   = '{sign: sign, exponent: 8'h00, mantissa: 23'h0};

        // A carry out of the rounding increment renormalises by one place.
        if (summed[24]) begin
            fraction = summed[23:1];
            hidden   = summed[24];
            finalExp = exponent + 11'sd1;
        end

        if (zeroFlag || (mantissa == '0) || !hidden || (finalExp <= 11'sd0)) begin
            result = '{sign: sign, exponent: 8'h00, mantissa: 23'h0};
        end else if (finalExp >= EXP_LIMIT) begin
            result = '{sign: sign, exponent: 8'hFF, mantissa: 23'h0};
        end else begin
            result = '{sign: sign, exponent: finalExp[7:0], mantissa: fraction};
        end
    end

endmodule

// File: rtl/float32_normalize.sv
// Multi-cycle normaliser: shifts a raw arithmetic result one place per cycle until
// the hidden bit is in position, then rounds and presents a Float32 with valid/ready.
import float32_normalize_pkg::*;

module float32_normalize (
    input  logic     aClock,
    input  logic     aReset,
    input  logic     anInValid,
    output logic     anInReady,
    input  RawFloat  anInput,
    output logic     anOutValid,
    input  logic     anOutReady,
    output Float32   anOutput
);

    NormState           state;
    NormState           nextState;
    logic               sign;
    logic signed [10:0] exponent;
    logic [MANT_W-1:0]  mantissa;
    logic               zeroFlag;
    Float32             rounded;
    Float32             resultReg;

    // Exponent carries one extra bit so shifting and rounding never wrap it.
    float32_round uRound (
        .sign     (sign),
        .exponent (exponent),
        .mantissa (mantissa),
        .zeroFlag (zeroFlag),
        .result   (rounded)
    );

    always_ff @(posedge aClock or posedge aReset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (aReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (anInValid) nextState = SHIFT;
            end
            SHIFT: begin
                if (mantissa == '0) begin
                    nextState = ROUND;
                end else if (mantissa[27]) begin
                    nextState = SHIFT;
                end else if ((mantissa[27:26] == 2'b00) && (exponent > 11'sd1)) begin
                    nextState = SHIFT;
                end else begin
                    nextState = ROUND;
                end
            end
            ROUND: nextState = DONE;
            DONE: begin
                if (anOutReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge aClock or posedge aReset) begin
        // NOTE: the datapath is reset too, so an operation in flight leaves no trace after reset.
        if (aReset) begin
            sign      <= 1'b0;
            exponent  <= '0;
            mantissa  <= '0;
            zeroFlag  <= 1'b0;
            resultReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anInValid) begin
                        sign     <= anInput.sign;
                        exponent <= {anInput.exponent[9], anInput.exponent};
                        mantissa <= anInput.mantissa;
                        zeroFlag <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (mantissa == '0) begin
                        zeroFlag <= 1'b1;
                    end else if (mantissa[27]) begin
                        // The bit shifted out of sticky stays folded into the new sticky.
                        mantissa <= {1'b0, mantissa[27:2], mantissa[1] | mantissa[0]};
                        exponent <= exponent + 11'sd1;
                    end else if ((mantissa[27:26] == 2'b00) && (exponent > 11'sd1)) begin
                        mantissa <= {mantissa[26:0], 1'b0};
                        exponent <= exponent - 11'sd1;
                    end
                end
                ROUND: resultReg <= rounded;
                default: ;
            endcase
        end
    end

    assign anInReady  = (state == IDLE);
    assign anOutValid = (state == DONE);
    assign anOutput   = resultReg;

endmodule

// File: tb/tb_float32_normalize.sv
// Directed bench for float32_normalize: latency, rounding, zero/infinity packing,
// output back-pressure and asynchronous reset in flight.
import float32_normalize_pkg::*;

module tb_float32_normalize;

    logic    aClock = 1'b0;
    logic    aReset = 1'b1;
    logic    anInValid = 1'b0;
    logic    anInReady;
    RawFloat anInput = '0;
    logic    anOutValid;
    logic    anOutReady = 1'b0;
    Float32  anOutput;

    int nAssert = 0;
    int nFail   = 0;

    localparam logic signed [9:0] E1 = 10'(BIAS);

    float32_normalize dut (
        .aClock     (aClock),
        .aReset     (aReset),
        .anInValid  (anInValid),
        .anInReady  (anInReady),
        .anInput    (anInput),
        .anOutValid (anOutValid),
        .anOutReady (anOutReady),
        .anOutput   (anOutput)
    );

    always #5 aClock = ~aClock;

    // Latency counts rising edges from the accepting edge (edge 1) until anOutValid is seen.
    task automatic runOp(input logic s, input logic signed [9:0] e, input logic [27:0] m,
                         output logic [31:0] res, output int lat);
        anInput.sign     = s;
        anInput.exponent = e;
        anInput.mantissa = m;
        anInValid        = 1'b1;
        @(posedge aClock); #1;
        anInValid = 1'b0;
        lat = 1;
        while (!anOutValid && lat < 40) begin
            @(posedge aClock); #1;
            lat++;
        end
        res = anOutput;
    endtask

    task automatic releaseOut;
        anOutReady = 1'b1;
        @(posedge aClock); #1;
        anOutReady = 1'b0;
    endtask

    task automatic test_reset;
        aReset = 1'b1;
        #12;
        nAssert++;
        if (anInReady !== 1'b1) begin
            nFail++; $display("FAIL reset_inReady: got %b want 1", anInReady);
        end
        nAssert++;
        if (anOutValid !== 1'b0) begin
            nFail++; $display("FAIL reset_outValid: got %b want 0", anOutValid);
        end
        nAssert++;
        if (anOutput !== 32'h0) begin
            nFail++; $display("FAIL reset_output: got %h want 00000000", anOutput);
        end
        #10 aReset = 1'b0;
        @(posedge aClock); #1;
    endtask

    typedef struct {
        string            name;
        logic             s;
        logic signed [9:0] e;
        logic [27:0]      m;
        logic [31:0]      want;
        int               lat;
    } Vec;

    task automatic runTable(input Vec v[]);
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < v.size(); i++) begin
            runOp(v[i].s, v[i].e, v[i].m, res, lat);
            nAssert++;
            if (res !== v[i].want) begin
                nFail++; $display("FAIL %s value: got %h want %h", v[i].name, res, v[i].want);
            end
            nAssert++;
            if (lat !== v[i].lat) begin
                nFail++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat);
            end
            releaseOut();
        end
    endtask

    task automatic test_shift;
        Vec v[] = '{
            '{"one",        1'b0, E1,      28'h4000000, 32'h3F800000, 3},
            '{"carry_in",   1'b0, E1,      28'h8000000, 32'h40000000, 4},
            '{"left23",     1'b0, 10'sd150, 28'h0000008, 32'h3F800000, 26},
            '{"neg_1p5",    1'b1, E1,      28'h6000000, 32'hBFC00000, 3}
        };
        runTable(v);
    endtask

    task automatic test_rounding;
        Vec v[] = '{
            '{"round_carry", 1'b0, E1,       28'h7FFFFFC, 32'h40000000, 3},
            '{"round_inf",   1'b0, 10'sd254, 28'h7FFFFFC, 32'h7F800000, 3},
            '{"tie_even",    1'b0, E1,       28'h4000004, 32'h3F800000, 3},
            '{"tie_odd",     1'b0, E1,       28'h400000C, 32'h3F800002, 3},
            '{"above_half",  1'b0, E1,       28'h4000006, 32'h3F800001, 3}
        };
        runTable(v);
    endtask

    task automatic test_zero;
        Vec v[] = '{
            '{"zero_mant",   1'b1, E1,        28'h0000000, 32'h80000000, 3},
            '{"neg_exp",     1'b1, -10'sd5,   28'h4000000, 32'h80000000, 3},
            '{"denorm_flush",1'b0, 10'sd2,    28'h0000001, 32'h00000000, 4}
        };
        runTable(v);
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int          lat;
        runOp(1'b0, E1, 28'h4000000, res, lat);
        anInValid        = 1'b1;
        anInput.sign     = 1'b1;
        anInput.exponent = 10'sd200;
        anInput.mantissa = 28'h8000000;
        for (int i = 0; i < 10; i++) begin
            @(posedge aClock); #1;
            nAssert++;
            if (anOutValid !== 1'b1) begin
                nFail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, anOutValid);
            end
            nAssert++;
            if (anOutput !== 32'h3F800000) begin
                nFail++; $display("FAIL stall_output[%0d]: got %h want 3F800000", i, anOutput);
            end
            nAssert++;
            if (anInReady !== 1'b0) begin
                nFail++; $display("FAIL stall_inReady[%0d]: got %b want 0", i, anInReady);
            end
        end
        anInput.sign     = 1'b0;
        anInput.exponent = E1 + 10'sd1;
        anInput.mantissa = 28'h4000000;
        anOutReady       = 1'b1;
        @(posedge aClock); #1;
        anOutReady = 1'b0;
        nAssert++;
        if ({anOutValid, anInReady} !== 2'b01) begin
            nFail++; $display("FAIL release_handshake: got valid,ready=%b want 01", {anOutValid, anInReady});
        end
        @(posedge aClock); #1;
        anInValid = 1'b0;
        nAssert++;
        if (anInReady !== 1'b0) begin
            nFail++; $display("FAIL next_accept: got inReady %b want 0", anInReady);
        end
        lat = 1;
        while (!anOutValid && lat < 40) begin
            @(posedge aClock); #1;
            lat++;
        end
        nAssert++;
        if (anOutput !== 32'h40000000 || lat !== 3) begin
            nFail++; $display("FAIL next_result: got %h lat %0d want 40000000 lat 3", anOutput, lat);
        end
        releaseOut();
    endtask

    task automatic test_reset_midflight;
        logic [31:0] res;
        int          lat;
        bit          sawValid;
        anInput.sign     = 1'b0;
        anInput.exponent = 10'sd150;
        anInput.mantissa = 28'h0000008;
        anInValid        = 1'b1;
        @(posedge aClock); #1;
        anInValid = 1'b0;
        repeat (5) @(posedge aClock);
        #3 aReset = 1'b1;
        #1;
        nAssert++;
        if ({anOutValid, anInReady} !== 2'b01) begin
            nFail++; $display("FAIL async_reset_flags: got valid,ready=%b want 01", {anOutValid, anInReady});
        end
        nAssert++;
        if (anOutput !== 32'h0) begin
            nFail++; $display("FAIL async_reset_output: got %h want 00000000", anOutput);
        end
        #2 aReset = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge aClock); #1;
            if (anOutValid) sawValid = 1'b1;
        end
        nAssert++;
        if (sawValid !== 1'b0) begin
            nFail++; $display("FAIL discarded_op: got output valid after reset want none");
        end
        runOp(1'b0, E1, 28'h4000000, res, lat);
        nAssert++;
        if (res !== 32'h3F800000 || lat !== 3) begin
            nFail++; $display("FAIL post_reset_op: got %h lat %0d want 3F800000 lat 3", res, lat);
        end
        releaseOut();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rounding();
        test_zero();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
